// File: rtl/branch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : branch_sequencer
// Brief   : Multi-cycle conditional-branch executor (brzr/brnz/brpl/brmi)
//           driving the register file, bus, CON flip-flop and PC write port.
// Revision: 1.0 - initial release
// ============================================================================
module branch_sequencer #(
    parameter int          DATA_W    = 32,
    parameter int          IMM_W     = 19,
    parameter logic [4:0]  BR_OPCODE = 5'b10010,
    parameter int          CON_WAIT  = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [31:0]       ir,
    input  logic [DATA_W-1:0] pc,
    output logic [3:0]        ra_sel,
    input  logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_drive,
    output logic [1:0]        c2_field,
    output logic              con_in,
    input  logic              con_flag,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_next,
    output logic              busy,
    output logic              done,
    output logic              taken,
    output logic              bad_op
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_COND   = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    localparam logic [2:0] c_WAIT_INIT = 3'(CON_WAIT - 1);

    logic [2:0]        r_state;
    logic [2:0]        r_wait;
    logic [DATA_W-1:0] r_pc;
    logic [IMM_W-1:0]  r_disp;
    logic [1:0]        r_c2;
    logic [3:0]        r_ra_sel;
    logic [DATA_W-1:0] r_bus_out;
    logic              r_bus_drive;
    logic [1:0]        r_c2_field;
    logic              r_con_in;
    logic              r_pc_load;
    logic [DATA_W-1:0] r_pc_next;
    logic              r_busy;
    logic              r_done;
    logic              r_taken;
    logic              r_bad_op;

    logic              w_is_br;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_target;
    logic              w_unused_ir;

    assign w_is_br     = (ir[31:27] == BR_OPCODE);
    assign w_sext      = {{(DATA_W-IMM_W){r_disp[IMM_W-1]}}, r_disp};
    // Wrap-around on the add is intentional: branch targets are modulo 2^DATA_W.
    assign w_target    = r_pc + w_sext;
    assign w_unused_ir = &{1'b0, ir};

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= S_IDLE;
            r_wait      <= 3'd0;
            r_pc        <= '0;
            r_disp      <= '0;
            r_c2        <= 2'd0;
            r_ra_sel    <= 4'd0;
            r_bus_out   <= '0;
            r_bus_drive <= 1'b0;
            r_c2_field  <= 2'd0;
            r_con_in    <= 1'b0;
            r_pc_load   <= 1'b0;
            r_pc_next   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_taken     <= 1'b0;
            r_bad_op    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pc     <= pc;
                        r_disp   <= ir[IMM_W-1:0];
                        r_c2     <= ir[1:0];
                        r_busy   <= 1'b1;
                        r_taken  <= 1'b0;
                        if (w_is_br) begin
                            r_ra_sel <= ir[26:23];
                            r_state  <= S_READ;
                        end else begin
                            // Non-branch opcode: finish next cycle, no read, no CON strobe.
                            r_done    <= 1'b1;
                            r_bad_op  <= 1'b1;
                            r_pc_load <= 1'b0;
                            r_pc_next <= pc;
                            r_state   <= S_UPDATE;
                        end
                    end
                end
                S_READ: begin
                    r_bus_out   <= ra_data;
                    r_bus_drive <= 1'b1;
                    r_c2_field  <= r_c2;
                    r_con_in    <= 1'b1;
                    r_state     <= S_COND;
                end
                S_COND: begin
                    r_con_in <= 1'b0;
                    r_wait   <= c_WAIT_INIT;
                    r_state  <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    if (r_wait == 3'd0) begin
                        r_taken     <= con_flag;
                        r_pc_load   <= con_flag;
                        r_pc_next   <= con_flag ? w_target : r_pc;
                        r_done      <= 1'b1;
                        r_bus_drive <= 1'b0;
                        r_state     <= S_UPDATE;
                    end else begin
                        r_wait <= r_wait - 3'd1;
                    end
                end
                S_UPDATE: begin
                    r_done    <= 1'b0;
                    r_bad_op  <= 1'b0;
                    r_pc_load <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ra_sel    = r_ra_sel;
    assign bus_out   = r_bus_out;
    assign bus_drive = r_bus_drive;
    assign c2_field  = r_c2_field;
    assign con_in    = r_con_in;
    assign pc_load   = r_pc_load;
    assign pc_next   = r_pc_next;
    assign busy      = r_busy;
    assign done      = r_done;
    assign taken     = r_taken;
    assign bad_op    = r_bad_op;

endmodule
`default_nettype wire

// File: tb/tb_branch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_branch_sequencer
// Brief   : Scoreboard bench for branch_sequencer with register-file and
//           CON flip-flop models.
// Revision: 1.0 - initial release
// ============================================================================
module tb_branch_sequencer;

    typedef struct packed {
        logic        taken;
        logic        pc_load;
        logic        bad_op;
        logic        busy;
        logic [31:0] pc_next;
        logic [7:0]  lat;
        logic [3:0]  ncon;
        logic [2:0]  post;
    } res_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [3:0]  ra_sel;
    logic [31:0] ra_data;
    logic [31:0] bus_out;
    logic        bus_drive;
    logic [1:0]  c2_field;
    logic        con_in;
    logic        con_flag;
    logic        pc_load;
    logic [31:0] pc_next;
    logic        busy;
    logic        done;
    logic        taken;
    logic        bad_op;

    logic [31:0] regs [16];
    logic        r_con_ff;
    res_t        sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    branch_sequencer dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .ir        (ir),
        .pc        (pc),
        .ra_sel    (ra_sel),
        .ra_data   (ra_data),
        .bus_out   (bus_out),
        .bus_drive (bus_drive),
        .c2_field  (c2_field),
        .con_in    (con_in),
        .con_flag  (con_flag),
        .pc_load   (pc_load),
        .pc_next   (pc_next),
        .busy      (busy),
        .done      (done),
        .taken     (taken),
        .bad_op    (bad_op)
    );

    assign ra_data  = regs[ra_sel];
    assign con_flag = r_con_ff;

    // CON flip-flop: 00 zero, 01 nonzero, 10 positive (MSB clear), 11 negative.
    always @(posedge clk) begin
        if (clr) r_con_ff <= 1'b0;
        else if (con_in) begin
            case (c2_field)
                2'b00:   r_con_ff <= (bus_out == 32'd0);
                2'b01:   r_con_ff <= (bus_out != 32'd0);
                2'b10:   r_con_ff <= ~bus_out[31];
                default: r_con_ff <= bus_out[31];
            endcase
        end
    end

    function automatic res_t model(input logic [31:0] f_ir, input logic [31:0] f_pc);
        res_t        r;
        logic [31:0] a;
        logic        c;
        r      = '0;
        r.busy = 1'b1;
        if (f_ir[31:27] != 5'b10010) begin
            r.bad_op  = 1'b1;
            r.pc_next = f_pc;
            r.lat     = 8'd1;
        end else begin
            a = regs[f_ir[26:23]];
            case (f_ir[1:0])
                2'b00:   c = (a == 32'd0);
                2'b01:   c = (a != 32'd0);
                2'b10:   c = ~a[31];
                default: c = a[31];
            endcase
            r.taken   = c;
            r.pc_load = c;
            r.pc_next = c ? f_pc + {{13{f_ir[18]}}, f_ir[18:0]} : f_pc;
            r.lat     = 8'd4;
            r.ncon    = 4'd1;
        end
        return r;
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [18:0] disp);
        return {op, ra, 4'd0, disp};
    endfunction

    // Called mid-cycle; start is sampled at the next rising edge.
    task automatic issue(input logic [31:0] t_ir, input logic [31:0] t_pc);
        start = 1'b1;
        ir    = t_ir;
        pc    = t_pc;
        @(posedge clk);
        #1;
        start = 1'b0;
        ir    = $urandom;
        pc    = $urandom;
    endtask

    task automatic wait_done(output res_t o);
        logic found;
        o     = '0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            o.lat = o.lat + 8'd1;
            if (con_in) o.ncon = o.ncon + 4'd1;
            if (done) begin
                found     = 1'b1;
                o.taken   = taken;
                o.pc_load = pc_load;
                o.bad_op  = bad_op;
                o.busy    = busy;
                o.pc_next = pc_next;
                break;
            end
        end
        if (!found) o.lat = 8'hFF;
        @(negedge clk);
        o.post = {done, pc_load, busy};
    endtask

    task automatic test_reset;
        clr   = 1'b1;
        start = 1'b1;
        ir    = mk_ir(5'b10010, 4'd3, 19'd8);
        pc    = 32'h100;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ra_sel, bus_out, bus_drive, c2_field, con_in, pc_load, pc_next,
             busy, done, taken, bad_op} !== 77'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: busy=%b done=%b pc_load=%b con_in=%b pc_next=%h required all zero",
                     busy, done, pc_load, con_in, pc_next);
        end
        clr   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, con_in} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_start_ignored: busy/done/con_in=%b required 000", {busy, done, con_in});
        end
    endtask

    task automatic test_brzr_taken;
        res_t e, o;
        regs[3] = 32'h0;
        e = '{taken:1'b1, pc_load:1'b1, bad_op:1'b0, busy:1'b1, pc_next:32'h108,
              lat:8'd4, ncon:4'd1, post:3'b000};
        sb.push_back(e);
        issue(mk_ir(5'b10010, 4'd3, 19'd8), 32'h100);
        wait_done(o);
        e = sb.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL brzr_taken: got %h required %h", o, e);
        end
    endtask

    task automatic test_brpl_not_taken;
        res_t e, o;
        regs[5] = 32'h8000_0001;
        e = '{taken:1'b0, pc_load:1'b0, bad_op:1'b0, busy:1'b1, pc_next:32'h200,
              lat:8'd4, ncon:4'd1, post:3'b000};
        sb.push_back(e);
        issue(mk_ir(5'b10010, 4'd5, 19'h0000A), 32'h200);
        wait_done(o);
        e = sb.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL brpl_not_taken: got %h required %h", o, e);
        end
    endtask

    task automatic test_neg_wrap;
        res_t e, o;
        regs[3] = 32'h0;
        e = '{taken:1'b1, pc_load:1'b1, bad_op:1'b0, busy:1'b1, pc_next:32'hFFFF_FFFC,
              lat:8'd4, ncon:4'd1, post:3'b000};
        sb.push_back(e);
        issue(mk_ir(5'b10010, 4'd3, 19'h7FFF8), 32'h4);
        wait_done(o);
        e = sb.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL neg_disp_wrap: got %h required %h", o, e);
        end
    endtask

    task automatic test_bad_op;
        res_t e, o;
        e = '{taken:1'b0, pc_load:1'b0, bad_op:1'b1, busy:1'b1, pc_next:32'h300,
              lat:8'd1, ncon:4'd0, post:3'b000};
        sb.push_back(e);
        issue(mk_ir(5'b00000, 4'd3, 19'd8), 32'h300);
        wait_done(o);
        e = sb.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL bad_opcode: got %h required %h", o, e);
        end
    endtask

    // start held for 6 cycles: the first accept completes in cycle 4 and the
    // still-high start in cycle 5 (one after done) launches a second operation.
    task automatic test_back_to_back;
        res_t        e, o;
        logic [31:0] ir_b;
        int          n_done, n_con;
        regs[3] = 32'h0;
        regs[5] = 32'h8000_0001;
        ir_b    = mk_ir(5'b10010, 4'd5, 19'h7FFFD);
        e = model(mk_ir(5'b10010, 4'd3, 19'd8), 32'h500);
        e.lat = 8'd4; e.ncon = 4'd0;
        sb.push_back(e);
        e = model(ir_b, 32'h1000);
        e.lat = 8'd9; e.ncon = 4'd0;
        sb.push_back(e);
        n_done = 0;
        n_con  = 0;
        start  = 1'b1;
        ir     = mk_ir(5'b10010, 4'd3, 19'd8);
        pc     = 32'h500;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            if (c <= 4) begin
                ir = $urandom;
                pc = $urandom;
            end else if (c == 5) begin
                ir = ir_b;
                pc = 32'h1000;
            end else if (c == 6) begin
                start = 1'b0;
            end
            @(negedge clk);
            if (con_in) n_con++;
            if (done) begin
                n_done++;
                o = '{taken:taken, pc_load:pc_load, bad_op:bad_op, busy:busy, pc_next:pc_next,
                      lat:8'(c), ncon:4'd0, post:3'b000};
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (o !== e) begin
                        n_bad++;
                        $display("FAIL back_to_back_op%0d: got %h required %h", n_done, o, e);
                    end
                end
            end
        end
        n_cmp++;
        if (n_done != 2 || n_con != 2 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL back_to_back_counts: done=%0d con_in=%0d left=%0d required 2 2 0",
                     n_done, n_con, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_random;
        res_t        e, o;
        logic [31:0] t_ir, t_pc;
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < 16; r++)
                regs[r] = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            t_ir = $urandom;
            if ($urandom_range(0, 4) != 0) t_ir[31:27] = 5'b10010;
            t_pc = $urandom;
            e = model(t_ir, t_pc);
            sb.push_back(e);
            issue(t_ir, t_pc);
            wait_done(o);
            e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL random_op%0d: ir=%h pc=%h got %h required %h", i, t_ir, t_pc, o, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        res_t e, o;
        int   n_stray;
        regs[3] = 32'h0;
        issue(mk_ir(5'b10010, 4'd3, 19'd8), 32'h400);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, bus_drive, done} !== 3'b110) begin
            n_bad++;
            $display("FAIL reset_mid_in_sample: busy/bus_drive/done=%b required 110",
                     {busy, bus_drive, done});
        end
        clr = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ra_sel, bus_out, bus_drive, c2_field, con_in, pc_load, pc_next,
             busy, done, taken, bad_op} !== 77'd0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b pc_load=%b pc_next=%h required all zero",
                     busy, done, pc_load, pc_next);
        end
        clr     = 1'b0;
        n_stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || pc_load || busy) n_stray++;
        end
        n_cmp++;
        if (n_stray != 0) begin
            n_bad++;
            $display("FAIL reset_mid_aborted: stray active cycles=%0d required 0", n_stray);
        end
        e = model(mk_ir(5'b10010, 4'd3, 19'h10), 32'h800);
        sb.push_back(e);
        issue(mk_ir(5'b10010, 4'd3, 19'h10), 32'h800);
        wait_done(o);
        e = sb.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL reset_mid_followup: got %h required %h", o, e);
        end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) regs[r] = $urandom;
        clr   = 1'b1;
        start = 1'b0;
        ir    = 32'd0;
        pc    = 32'd0;
        test_reset;
        test_brzr_taken;
        test_brpl_not_taken;
        test_neg_wrap;
        test_bad_op;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Multi-cycle controller that executes conditional-branch instructions (brzr/brnz/brpl/brmi) on the datapath side of the CON flip-flop.
- Sequence: read register Ra, place it on the bus, drive the IR condition field to the CON FF, strobe CON_in, sample CON_out.
- If the branch is taken, load PC with PC + sign-extended displacement.
- Sits between the control unit (start/done handshake) and the register file, bus, CON FF and PC register.

Parameters:
- DATA_W, 32, datapath/bus/PC width.
- IMM_W, 19, displacement field width (IR[18:0]).
- BR_OPCODE, 5'b10010, IR[31:27] value identifying a conditional branch.
- CON_WAIT, 1, cycles between the end of the CON_in strobe and sampling of con_flag (1..7).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  synchronous active-high reset.
- start  in  1  one-cycle request from the control unit; accepted only in IDLE.
- ir  in  32  instruction word; captured on an accepted start.
- pc  in  32  current PC; captured on an accepted start.
- ra_sel  out  4  register-file read select, = captured IR[26:23].
- ra_data  in  32  register-file read data; valid the cycle after ra_sel is driven.
- bus_out  out  32  value driven onto the bus for the CON FF.
- bus_drive  out  1  bus enable for bus_out.
- c2_field  out  2  condition select to the CON FF, = captured IR[1:0].
- con_in  out  1  CON FF load strobe.
- con_flag  in  1  CON FF output.
- pc_load  out  1  one-cycle PC write enable.
- pc_next  out  32  PC write data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- taken  out  1  branch result; valid while done = 1 and held until the next accept.
- bad_op  out  1  one-cycle pulse, coincident with done, when IR[31:27] != BR_OPCODE.

Behaviour:
- Reset: clr = 1 at a clock edge forces state IDLE and clears all registered outputs (busy, done, taken, bad_op, pc_load, con_in, bus_drive, bus_out, pc_next, ra_sel, c2_field) to 0. clr overrides any in-flight operation, and no pc_load may be issued afterward.
- States: IDLE -> READ -> COND -> SAMPLE -> UPDATE -> IDLE.
- IDLE: on start = 1, capture ir and pc, then go to READ.
  - If the captured opcode mismatches BR_OPCODE, go directly to UPDATE with taken = 0 and bad_op set. No register read and no CON strobe occur.
- READ (1 cycle): ra_sel driven; ra_data latched into an internal register at the end of the cycle.
- COND (1 cycle):
  - bus_drive = 1, bus_out = latched Ra, c2_field = IR[1:0], con_in = 1.
  - bus_drive and c2_field stay stable through SAMPLE.
- SAMPLE: con_in = 0. Count CON_WAIT cycles, then latch con_flag into taken.
- UPDATE (1 cycle):
  - done = 1 and bus_drive = 0.
  - If taken: pc_load = 1, pc_next = pc + sext(IR[18:0]), modulo 2^32 (wrap-around is silent, no overflow flag).
  - If not taken: pc_load = 0 and pc_next = captured pc.
- Latency: start to done = 3 + CON_WAIT cycles (4 at default) for a valid branch; 1 cycle for bad_op.
- start while busy: ignored, with no effect on the in-flight operation. start coincident with clr: ignored.
- ir and pc may change after an accept; the sequencer uses only the captured copies.
- con_in is exactly one cycle wide per operation; never asserted outside COND.

Test Plan:
- Branch if zero taken: R3 = 0x00000000, IR = brzr R3 with disp +8 (c2 = 00), pc = 0x100 → con_in pulse at cycle 2; done at cycle 4 with taken = 1, pc_load = 1, pc_next = 0x108.
- Branch if positive, not taken: R5 = 0x80000001 (c2 = 10) → taken = 0, pc_load = 0, pc_next = pc.
- Negative displacement with wrap: pc = 0x00000004, disp = 0x7FFF8 (−8), branch taken → pc_next = 0xFFFFFFFC.
- Bad opcode: IR[31:27] = 00000 → done and bad_op high one cycle after start; con_in never asserted; pc_load = 0.
- Protocol robustness: start held high for 6 cycles → exactly one done pulse from the first accept; a second start issued one cycle after done is accepted normally.
- Reset mid-operation: clr pulsed during SAMPLE → next cycle all outputs 0 and state IDLE; no pc_load or done for the aborted operation; a following start completes normally.
